// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, row
// drive idle pattern and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1110;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Indexed by {row, col}; entry 0 is row 0 / column 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,
        4'hC, 4'h9,     4'h8, 4'h7,
        4'hB, 4'h6,     4'h5, 4'h4,
        4'hA, 4'h3,     4'h2, 4'h1
    };

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the scanner. The scanner uses the
// master modport; the keypad/consumer side uses slave.
interface keypad_scanner_if;
    logic [3:0] rowwrite;
    logic [3:0] colread;
    logic [3:0] keyout;
    logic       ready;
    logic       ack;

    modport master (
        output rowwrite, keyout, ready,
        input  colread, ack
    );

    modport slave (
        input  rowwrite, keyout, ready,
        output colread, ack
    );
endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous column sense lines. Resets to
// all-ones so nothing looks pressed until real samples arrive.
module keypad_col_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based debounce and a ready/ack
// handshake. Define KEYPAD_AUTOREPEAT_EN to re-report a key held after ack.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_SCANS   = 500
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  bus
);
    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE_SCANS);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_N    = CNT_W'(REPEAT_SCANS);
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [3:0]       row_drv;
    logic             acc_hit;
    logic [3:0]       acc_code;

    logic             div_tc, frame_end;
    logic             slot_hit;
    logic [1:0]       slot_col;
    logic             fhit;
    logic [3:0]       fcode;

    state_t           state;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       key_q;
    logic             ready_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_cnt;
`endif

    keypad_col_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.colread),
        .q   (col_s)
    );

    assign bus.rowwrite = row_drv;
    assign bus.keyout   = key_q;
    assign bus.ready    = ready_q;

    assign div_tc    = (div_cnt == DIV_LAST);
    assign frame_end = div_tc && (row_idx == 2'd3);

    // Lowest-numbered low column wins within the current row.
    always_comb begin
        slot_hit = 1'b0;
        slot_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_s[c]) begin
                slot_hit = 1'b1;
                slot_col = 2'(c);
            end
        end
    end

    // Result of the frame that closes this cycle, folding in the row 3 slot.
    assign fhit  = acc_hit | slot_hit;
    assign fcode = acc_hit ? acc_code : key_code(row_idx, slot_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            row_idx  <= 2'd0;
            row_drv  <= ROW_IDLE;
            acc_hit  <= 1'b0;
            acc_code <= 4'h0;
        end else if (div_tc) begin
            div_cnt <= '0;
            row_idx <= row_idx + 2'd1;
            row_drv <= {row_drv[2:0], row_drv[3]};
            if (frame_end) begin
                acc_hit  <= 1'b0;
                acc_code <= 4'h0;
            end else if (!acc_hit && slot_hit) begin
                acc_hit  <= 1'b1;
                acc_code <= key_code(row_idx, slot_col);
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCAN;
            cand    <= 4'h0;
            cnt     <= '0;
            key_q   <= 4'h0;
            ready_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            case (state)
                SCAN: begin
                    if (frame_end && fhit) begin
                        cand  <= fcode;
                        cnt   <= CNT_W'(1);
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (frame_end) begin
                        if (!fhit) begin
                            cnt   <= '0;
                            state <= SCAN;
                        end else if (fcode == cand) begin
                            if (sat_inc(cnt) >= DEB_N) begin
                                key_q   <= cand;
                                ready_q <= 1'b1;
                                cnt     <= '0;
                                state   <= WAIT_ACK;
                            end else begin
                                cnt <= sat_inc(cnt);
                            end
                        end else begin
                            cand <= fcode;
                            cnt  <= CNT_W'(1);
                        end
                    end
                end
                WAIT_ACK: begin
                    // A frame ending on the ack cycle is dropped, not counted.
                    if (bus.ack) begin
                        ready_q <= 1'b0;
                        cnt     <= '0;
                        state   <= RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt <= '0;
`endif
                    end
                end
                RELEASE: begin
                    if (frame_end) begin
                        if (!fhit) begin
                            if (sat_inc(cnt) >= DEB_N) begin
                                cnt   <= '0;
                                state <= SCAN;
                            end else begin
                                cnt <= sat_inc(cnt);
                            end
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt <= '0;
                        end else if (fcode == key_q) begin
                            cnt <= '0;
                            if (sat_inc(rep_cnt) >= REP_N) begin
                                ready_q <= 1'b1;
                                rep_cnt <= '0;
                                state   <= WAIT_ACK;
                            end else begin
                                rep_cnt <= sat_inc(rep_cnt);
                            end
                        end else begin
                            cnt     <= '0;
                            rep_cnt <= '0;
                        end
`else
                        end else begin
                            cnt <= '0;
                        end
`endif
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model pulls columns low for
// pressed keys on the driven row; cycle numbers are edges since reset release.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_scanner_if bus();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] keys = '0;
    int cyc = 0;
    int base = 0;
    int rises = 0;
    int last_rise = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int r0;
    logic ready_q = 1'b0;

    always_comb begin
        bus.colread = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && bus.rowwrite[r] == 1'b0) bus.colread[c] = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ready === 1'b1 && ready_q !== 1'b1) begin
            rises++;
            last_rise = cyc;
        end
        ready_q = bus.ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ack = 1'b0;
        keys = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic at(input int k);
        while (cyc - base < k) @(negedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        @(negedge clk);
        #1;
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        keys[6] = 1'b1;
        at(37);
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL rst_pre_ready: got %0b want 1", bus.ready); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus.rowwrite !== 4'b1110) begin n_bad++; $display("FAIL rst_row: got %b want 1110", bus.rowwrite); end
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", bus.ready); end
        n_cmp++; if (bus.keyout !== 4'h0) begin n_bad++; $display("FAIL rst_keyout: got %h want 0", bus.keyout); end
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
        r0 = rises;
        at(3);
        n_cmp++; if (bus.rowwrite !== 4'b1110) begin n_bad++; $display("FAIL rot_3: got %b want 1110", bus.rowwrite); end
        at(4);
        n_cmp++; if (bus.rowwrite !== 4'b1101) begin n_bad++; $display("FAIL rot_4: got %b want 1101", bus.rowwrite); end
        at(8);
        n_cmp++; if (bus.rowwrite !== 4'b1011) begin n_bad++; $display("FAIL rot_8: got %b want 1011", bus.rowwrite); end
        at(12);
        n_cmp++; if (bus.rowwrite !== 4'b0111) begin n_bad++; $display("FAIL rot_12: got %b want 0111", bus.rowwrite); end
        at(16);
        n_cmp++; if (bus.rowwrite !== 4'b1110) begin n_bad++; $display("FAIL rot_16: got %b want 1110", bus.rowwrite); end
        at(33);
        n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL rst_rereport: got %0d readies want 1", rises - r0); end
        n_cmp++; if (last_rise - base !== 32) begin n_bad++; $display("FAIL rst_rereport_cyc: got %0d want 32", last_rise - base); end
        n_cmp++; if (bus.keyout !== 4'h6) begin n_bad++; $display("FAIL rst_rereport_key: got %h want 6", bus.keyout); end
    endtask

    task automatic test_single();
        do_reset();
        keys[6] = 1'b1;
        r0 = rises;
        at(50);
        n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL single_ready: got %0d readies want 1", rises - r0); end
        n_cmp++; if (last_rise - base !== 32) begin n_bad++; $display("FAIL single_latency: got %0d want 32", last_rise - base); end
        n_cmp++; if (bus.keyout !== 4'h6) begin n_bad++; $display("FAIL single_key: got %h want 6", bus.keyout); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL single_hold: got %0b want 1", bus.ready); end
        pulse_ack();
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL single_ack: got %0b want 0", bus.ready); end
        n_cmp++; if (bus.keyout !== 4'h6) begin n_bad++; $display("FAIL single_keep: got %h want 6", bus.keyout); end
`ifndef KEYPAD_AUTOREPEAT_EN
        at(131);
        n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL single_norepeat: got %0d readies want 1", rises - r0); end
`endif
    endtask

    task automatic test_bounce();
        do_reset();
        keys[0] = 1'b1;
        r0 = rises;
        at(16);
        keys[0] = 1'b0;
        at(32);
        keys[0] = 1'b1;
        at(63);
        n_cmp++; if (rises - r0 !== 0) begin n_bad++; $display("FAIL bounce_early: got %0d readies want 0", rises - r0); end
        at(64);
        n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL bounce_ready: got %0d readies want 1", rises - r0); end
        n_cmp++; if (bus.keyout !== 4'h1) begin n_bad++; $display("FAIL bounce_key: got %h want 1", bus.keyout); end
    endtask

    task automatic test_two_keys();
        do_reset();
        pulse_ack();
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL stray_ack: got %0b want 0", bus.ready); end
        keys[12] = 1'b1;
        keys[14] = 1'b1;
        r0 = rises;
        at(40);
        n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL two_ready: got %0d readies want 1", rises - r0); end
        n_cmp++; if (last_rise - base !== 32) begin n_bad++; $display("FAIL two_cyc: got %0d want 32", last_rise - base); end
        n_cmp++; if (bus.keyout !== 4'hE) begin n_bad++; $display("FAIL two_key: got %h want e", bus.keyout); end
    endtask

    task automatic test_release_gating();
        do_reset();
        keys[14] = 1'b1;
        r0 = rises;
        at(32);
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL gate_first: got %0b want 1", bus.ready); end
        n_cmp++; if (bus.keyout !== 4'hF) begin n_bad++; $display("FAIL gate_first_key: got %h want f", bus.keyout); end
        pulse_ack();
        at(48);
        keys[14] = 1'b0;
        at(64);
        keys[14] = 1'b1;
        at(96);
        n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL gate_held: got %0d readies want 1", rises - r0); end
        keys[14] = 1'b0;
        at(128);
        keys[14] = 1'b1;
        at(159);
        n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL gate_early: got %0d readies want 1", rises - r0); end
        at(160);
        n_cmp++; if (rises - r0 !== 2) begin n_bad++; $display("FAIL gate_second: got %0d readies want 2", rises - r0); end
        n_cmp++; if (bus.keyout !== 4'hF) begin n_bad++; $display("FAIL gate_second_key: got %h want f", bus.keyout); end
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        do_reset();
        keys[13] = 1'b1;
        r0 = rises;
        at(32);
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL rep_first: got %0b want 1", bus.ready); end
        pulse_ack();
        at(79);
        n_cmp++; if (rises - r0 !== 1) begin n_bad++; $display("FAIL rep_early: got %0d readies want 1", rises - r0); end
        at(80);
        n_cmp++; if (rises - r0 !== 2) begin n_bad++; $display("FAIL rep_again: got %0d readies want 2", rises - r0); end
        n_cmp++; if (bus.keyout !== 4'h0) begin n_bad++; $display("FAIL rep_key: got %h want 0", bus.keyout); end
        pulse_ack();
        at(112);
        keys[13] = 1'b0;
        at(160);
        n_cmp++; if (rises - r0 !== 2) begin n_bad++; $display("FAIL rep_released: got %0d readies want 2", rises - r0); end
    endtask
`endif

    initial begin
        bus.ack = 1'b0;
        test_reset();
        test_single();
        test_bounce();
        test_two_keys();
        test_release_gating();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
